// File: rtl/ram_access_arbiter.sv
// Arbitrates IF fetches and LS loads/stores onto the single-port data RAM. Sub-word stores become read-modify-write.
// Latency: 1 clk accept->rsp for reads, word stores and errors; 2 clk for RMW stores. No response back-pressure.
module ram_access_arbiter #(
  parameter int ADDR_W       = 10,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req_valid,
  output logic              if_req_ready,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_rsp_valid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              ls_req_valid,
  output logic              ls_req_ready,
  input  logic              ls_we,
  input  logic [1:0]        ls_size,
  input  logic [1:0]        ls_byte_off,
  input  logic [ADDR_W-1:0] ls_addr,
  input  logic [DATA_W-1:0] ls_wdata,
  output logic              ls_rsp_valid,
  output logic [DATA_W-1:0] ls_rdata,
  output logic              ls_err,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, RD, WR, ERR} state_t;

  localparam int STREAK_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(STARVE_LIMIT);

  state_t              state;
  logic [STREAK_W-1:0] ls_streak;
  logic                cur_ls;
  logic                cur_store;
  logic [1:0]          cur_size;
  logic [1:0]          cur_off;
  logic [DATA_W-1:0]   cur_wdata;

  logic idle;
  logic if_starved;
  logic ls_grant;
  logic if_grant;
  logic ls_illegal;

  assign idle       = rst_n && (state == IDLE);
  assign if_starved = if_req_valid && (ls_streak == STREAK_MAX);
  assign ls_grant   = idle && ls_req_valid && !if_starved;
  assign if_grant   = idle && if_req_valid && !ls_grant;
  assign ls_req_ready = ls_grant;
  assign if_req_ready = if_grant;
  assign busy         = (state != IDLE);

  assign ls_illegal = (ls_size == 2'b11) ||
                      (ls_size == 2'b01 && ls_byte_off[0]) ||
                      (ls_size == 2'b10 && ls_byte_off != 2'b00);

  // Lay right-aligned store data into the addressed lane(s) of the old word.
  function automatic logic [DATA_W-1:0] merge_lanes(input logic [DATA_W-1:0] word,
                                                    input logic [DATA_W-1:0] data,
                                                    input logic [1:0]        size,
                                                    input logic [1:0]        off);
    logic [DATA_W-1:0] m;
    m = word;
    if (size == 2'b00)
      m[{off, 3'b000} +: 8] = data[7:0];
    else
      m[{off[1], 4'b0000} +: 16] = data[15:0];
    return m;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      ls_streak    <= '0;
      cur_ls       <= 1'b0;
      cur_store    <= 1'b0;
      cur_size     <= 2'b00;
      cur_off      <= 2'b00;
      cur_wdata    <= '0;
      if_rsp_valid <= 1'b0;
      if_rdata     <= '0;
      ls_rsp_valid <= 1'b0;
      ls_rdata     <= '0;
      ls_err       <= 1'b0;
      ram_we       <= 1'b0;
      ram_addr     <= '0;
      ram_wdata    <= '0;
    end else begin
      if_rsp_valid <= 1'b0;
      ls_rsp_valid <= 1'b0;
      ls_err       <= 1'b0;
      case (state)
        IDLE: begin
          if (ls_grant) begin
            cur_ls    <= 1'b1;
            cur_store <= ls_we;
            cur_size  <= ls_size;
            cur_off   <= ls_byte_off;
            cur_wdata <= ls_wdata;
            if (!if_req_valid)
              ls_streak <= '0;
            else if (ls_streak != STREAK_MAX)
              ls_streak <= ls_streak + 1'b1;
            if (ls_illegal) begin
              state <= ERR;
            end else if (ls_we && ls_size == 2'b10) begin
              ram_addr  <= ls_addr;
              ram_wdata <= ls_wdata;
              ram_we    <= 1'b1;
              state     <= WR;
            end else begin
              ram_addr <= ls_addr;
              ram_we   <= 1'b0;
              state    <= RD;
            end
          end else if (if_grant) begin
            cur_ls    <= 1'b0;
            cur_store <= 1'b0;
            ls_streak <= '0;
            ram_addr  <= if_addr;
            ram_we    <= 1'b0;
            state     <= RD;
          end
        end
        RD: begin
          if (cur_store) begin
            ram_wdata <= merge_lanes(ram_rdata, cur_wdata, cur_size, cur_off);
            ram_we    <= 1'b1;
            state     <= WR;
          end else begin
            if (cur_ls) begin
              ls_rdata     <= ram_rdata;
              ls_rsp_valid <= 1'b1;
            end else begin
              if_rdata     <= ram_rdata;
              if_rsp_valid <= 1'b1;
            end
            state <= IDLE;
          end
        end
        WR: begin
          ram_we       <= 1'b0;
          ls_rsp_valid <= 1'b1;
          state        <= IDLE;
        end
        ERR: begin
          ls_rsp_valid <= 1'b1;
          ls_err       <= 1'b1;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_access_arbiter.sv
// Directed bench for ram_access_arbiter: LS vector table against a behavioural RAM, plus
// hand-written sequences for simultaneous requests, IF starvation and reset during a write.
module tb_ram_access_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_req_valid, if_req_ready, if_rsp_valid;
  logic [9:0]  if_addr;
  logic [31:0] if_rdata;
  logic        ls_req_valid, ls_req_ready, ls_we, ls_rsp_valid, ls_err;
  logic [1:0]  ls_size, ls_byte_off;
  logic [9:0]  ls_addr;
  logic [31:0] ls_wdata, ls_rdata;
  logic        ram_we, busy;
  logic [9:0]  ram_addr;
  logic [31:0] ram_wdata, ram_rdata;

  always #5 clk = ~clk;

  ram_access_arbiter #(.ADDR_W(10), .DATA_W(32), .STARVE_LIMIT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_addr(if_addr),
    .if_rsp_valid(if_rsp_valid), .if_rdata(if_rdata),
    .ls_req_valid(ls_req_valid), .ls_req_ready(ls_req_ready), .ls_we(ls_we),
    .ls_size(ls_size), .ls_byte_off(ls_byte_off), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
    .ls_rsp_valid(ls_rsp_valid), .ls_rdata(ls_rdata), .ls_err(ls_err),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .busy(busy)
  );

  // RAM model: read data follows the address within the cycle, writes land on the clock edge.
  logic [31:0] mem [0:1023];
  assign ram_rdata = mem[ram_addr];
  always @(posedge clk) if (ram_we) mem[ram_addr] <= ram_wdata;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic [1:0]  off;
    logic [9:0]  addr;
    logic [31:0] wdata;
    logic        err;
    int          lat;
    logic [31:0] exp_word;
  } vec_t;

  vec_t vecs [14];

  task automatic ls_txn(input vec_t v, input int idx);
    bit accepted;
    bit got;
    int lat;
    int we_cnt;
    string nm;
    nm = $sformatf("vec%0d", idx);
    ls_we = v.we; ls_size = v.size; ls_byte_off = v.off; ls_addr = v.addr; ls_wdata = v.wdata;
    ls_req_valid = 1'b1;
    accepted = 1'b0;
    for (int i = 0; i < 10 && !accepted; i++) begin
      #1;
      if (ls_req_ready) accepted = 1'b1;
      @(posedge clk); #1;
    end
    // Scramble the request inputs: the DUT must work from its latched copy.
    ls_req_valid = 1'b0;
    ls_addr  = v.addr ^ 10'h3FF;
    ls_wdata = ~v.wdata;
    ls_byte_off = ~v.off;
    check({nm, " accept"}, 32'(accepted), 32'd1);
    got = 1'b0; lat = -1; we_cnt = 0;
    for (int c = 0; c <= 6 && !got; c++) begin
      if (ram_we) we_cnt++;
      if (ls_rsp_valid) begin
        got = 1'b1;
        lat = c;
      end else begin
        @(posedge clk); #1;
      end
    end
    check({nm, " latency"}, 32'(lat), 32'(v.lat));
    check({nm, " ls_err"}, 32'(ls_err), 32'(v.err));
    check({nm, " ram_we cycles"}, 32'(we_cnt), (v.we && !v.err) ? 32'd1 : 32'd0);
    if (!v.we && !v.err) check({nm, " ls_rdata"}, ls_rdata, v.exp_word);
    else                 check({nm, " ram word"}, mem[v.addr], v.exp_word);
    @(posedge clk); #1;
    check({nm, " rsp pulse ends"}, 32'(ls_rsp_valid), 32'd0);
  endtask

  string grant_seq [6];
  string exp_seq   [6];

  initial begin
    //             we    size   off    addr    wdata          err  lat exp_word
    vecs[0]  = '{1'b1, 2'b10, 2'b00, 10'h005, 32'hDEADBEEF, 1'b0, 1, 32'hDEADBEEF};
    vecs[1]  = '{1'b0, 2'b10, 2'b00, 10'h005, 32'h00000000, 1'b0, 1, 32'hDEADBEEF};
    vecs[2]  = '{1'b1, 2'b10, 2'b00, 10'h000, 32'h11111111, 1'b0, 1, 32'h11111111};
    vecs[3]  = '{1'b1, 2'b00, 2'b10, 10'h000, 32'h000000AB, 1'b0, 2, 32'h11AB1111};
    vecs[4]  = '{1'b0, 2'b10, 2'b00, 10'h000, 32'h00000000, 1'b0, 1, 32'h11AB1111};
    vecs[5]  = '{1'b1, 2'b01, 2'b01, 10'h000, 32'h00005555, 1'b1, 1, 32'h11AB1111};
    vecs[6]  = '{1'b1, 2'b01, 2'b10, 10'h000, 32'h0000CAFE, 1'b0, 2, 32'hCAFE1111};
    vecs[7]  = '{1'b1, 2'b00, 2'b00, 10'h005, 32'hFFFFFF77, 1'b0, 2, 32'hDEADBE77};
    vecs[8]  = '{1'b1, 2'b10, 2'b01, 10'h005, 32'h00000000, 1'b1, 1, 32'hDEADBE77};
    vecs[9]  = '{1'b0, 2'b11, 2'b00, 10'h005, 32'h00000000, 1'b1, 1, 32'hDEADBE77};
    vecs[10] = '{1'b1, 2'b01, 2'b00, 10'h005, 32'hFFFF1234, 1'b0, 2, 32'hDEAD1234};
    vecs[11] = '{1'b0, 2'b00, 2'b01, 10'h000, 32'h00000000, 1'b0, 1, 32'hCAFE1111};
    vecs[12] = '{1'b1, 2'b00, 2'b11, 10'h000, 32'h0000009A, 1'b0, 2, 32'h9AFE1111};
    vecs[13] = '{1'b0, 2'b01, 2'b11, 10'h000, 32'h00000000, 1'b1, 1, 32'h9AFE1111};

    // Reset: readies held low even with both requests pending.
    rst_n = 1'b0;
    if_req_valid = 1'b1; if_addr = '0;
    ls_req_valid = 1'b1; ls_we = 1'b0; ls_size = 2'b10; ls_byte_off = 2'b00;
    ls_addr = '0; ls_wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset ls_req_ready", 32'(ls_req_ready), 32'd0);
    check("reset if_req_ready", 32'(if_req_ready), 32'd0);
    if_req_valid = 1'b0; ls_req_valid = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    check("reset busy", 32'(busy), 32'd0);
    check("reset ram_we", 32'(ram_we), 32'd0);
    check("reset ram_addr", 32'(ram_addr), 32'd0);
    check("reset rsp_valid", {30'd0, if_rsp_valid, ls_rsp_valid}, 32'd0);

    for (int i = 0; i < 14; i++) ls_txn(vecs[i], i);

    // Simultaneous first requests with a cleared streak: LS first, IF in the next IDLE.
    ls_we = 1'b0; ls_size = 2'b10; ls_byte_off = 2'b00; ls_addr = 10'h005;
    ls_req_valid = 1'b1; if_req_valid = 1'b1; if_addr = 10'h000;
    #1;
    check("simul ls_req_ready", 32'(ls_req_ready), 32'd1);
    check("simul if_req_ready", 32'(if_req_ready), 32'd0);
    @(posedge clk); #1;
    ls_req_valid = 1'b0;
    begin
      int k;
      k = -1;
      for (int j = 0; j < 6 && k < 0; j++) begin
        #1;
        if (if_req_ready) k = j;
        else begin @(posedge clk); #1; end
      end
      check("simul ls_rdata", ls_rdata, 32'hDEAD1234);
      check("simul IF wait", 32'(k), 32'd1);
    end
    @(posedge clk); #1;
    if_req_valid = 1'b0;
    @(posedge clk); #1;
    check("simul if_rsp_valid", 32'(if_rsp_valid), 32'd1);
    check("simul if_rdata", if_rdata, 32'h9AFE1111);
    @(posedge clk); #1;

    // Starvation: both requesters valid throughout.
    exp_seq = '{"LS", "LS", "LS", "LS", "IF", "LS"};
    ls_req_valid = 1'b1; if_req_valid = 1'b1; if_addr = 10'h005;
    begin
      int n;
      int rsp_k;
      n = 0; rsp_k = -1;
      for (int k = 0; k < 30 && !(n == 6 && rsp_k >= 0); k++) begin
        #1;
        if (if_rsp_valid && rsp_k < 0) rsp_k = k;
        if (n < 6) begin
          if (ls_req_ready) begin grant_seq[n] = "LS"; n++; end
          else if (if_req_ready) begin grant_seq[n] = "IF"; n++; end
        end
        @(posedge clk); #1;
      end
      check("starve grant count", 32'(n), 32'd6);
      for (int g = 0; g < 6; g++) begin
        tests++;
        if (grant_seq[g] != exp_seq[g]) begin
          fails++;
          $display("FAIL starve grant %0d: got %s, expected %s", g, grant_seq[g], exp_seq[g]);
        end
      end
      check("starve if_rsp within 10", 32'(rsp_k >= 1 && rsp_k <= 10), 32'd1);
      check("starve if_rdata", if_rdata, 32'hDEAD1234);
    end
    ls_req_valid = 1'b0; if_req_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    // Reset asserted while an RMW store is in its write cycle.
    ls_we = 1'b1; ls_size = 2'b00; ls_byte_off = 2'b01; ls_addr = 10'h010; ls_wdata = 32'h55;
    ls_req_valid = 1'b1;
    #1;
    check("rmw-reset accept", 32'(ls_req_ready), 32'd1);
    @(posedge clk); #1;
    ls_req_valid = 1'b0;
    @(posedge clk); #1;
    check("rmw-reset in WR ram_we", 32'(ram_we), 32'd1);
    check("rmw-reset in WR busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("rmw-reset async ram_we", 32'(ram_we), 32'd0);
    check("rmw-reset async busy", 32'(busy), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    begin
      int rsp_cnt;
      rsp_cnt = 0;
      for (int c = 0; c < 5; c++) begin
        @(posedge clk); #1;
        if (ls_rsp_valid) rsp_cnt++;
      end
      check("rmw-reset no ls_rsp", 32'(rsp_cnt), 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
